// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the fetch slice: default widths, reset vector,
// NOP encoding and the fetch FSM state encoding.
package rv32_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if #(
  parameter int XLEN = rv32_pkg::XLEN_DEFAULT
);

  // Handshake: a request transfers in any cycle where imem_req and imem_gnt
  // are both high. imem_addr must hold while imem_req waits for imem_gnt.
  // Each accepted request yields exactly one imem_rvalid pulse, in order,
  // carrying the instruction word on imem_rdata; there is no response
  // back-pressure.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one instruction slot with load, clear and
// valid/ready consumption. Clear beats load; consumption frees the slot.
module if_id_reg
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic            ready,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc4,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Payload is left untouched on clear so the stale word stays visible
  // for debug; only valid qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      pc4   <= '0;
    end else if (load && !clear) begin
      instr <= load_instr;
      pc    <= load_pc;
      pc4   <= load_pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: pc register, fetch FSM with redirect/kill
// handling, and an IF/ID slot that buffers one fetched instruction.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_sel,
  input  logic [XLEN-1:0]     br_target,
  fetch_unit_if.master        imem,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [XLEN-1:0]     if_pc4,
  input  logic                id_ready,
  output fetch_state_t        state
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;
  logic            kill;
  logic            kill_next;
  logic            run;
  logic            req;
  logic            accept;
  logic            slot_busy;
  logic            load;

  assign target    = br_target & ~XLEN'(3);
  assign pc_inc    = pc + XLEN'(4);
  assign slot_busy = if_valid && !id_ready;

  // run keeps imem_req low during reset and lets it rise on the first edge
  // after release. A full, stalled IF/ID slot blocks new requests so the
  // single in-flight response always has somewhere to land.
  assign req    = run && (state_q == ST_FETCH) && !slot_busy;
  assign accept = req && imem.imem_gnt;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign state          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      run     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_next;
      kill    <= kill_next;
      run     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_next   = pc;
    kill_next = kill;
    load      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (slot_busy) begin
          state_d = ST_HOLD;
        end else if (accept) begin
          state_d   = ST_WAIT;
          kill_next = pc_sel;
        end
      end

      // A killed or redirect-coincident response is swallowed whole:
      // no IF/ID load and no pc advance.
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d   = ST_FETCH;
          kill_next = 1'b0;
          if (!kill && !pc_sel) begin
            load    = 1'b1;
            pc_next = pc_inc;
          end
        end else if (pc_sel) begin
          kill_next = 1'b1;
        end
      end

      ST_HOLD: begin
        if (if_valid && id_ready) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d   = ST_FETCH;
        kill_next = 1'b0;
      end
    endcase

    // Redirect wins over everything; the slot is cleared so HOLD has
    // nothing left to wait for.
    if (pc_sel) begin
      pc_next = target;
      if (state_d == ST_HOLD) begin
        state_d = ST_FETCH;
      end
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clear      (pc_sel),
    .ready      (id_ready),
    .load_instr (imem.imem_rdata),
    .load_pc    (pc),
    .load_pc4   (pc_inc),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc4        (if_pc4)
  );

endmodule
